// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// bcd_out is registered and only updated when a conversion completes.
module bin2bcd_seq #(
  parameter int N_in  = 10,
  parameter int N_dig = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N_in-1:0]      bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_dig-1:0]   bcd_out
);

  localparam int CW = $clog2(N_in + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t               state;
  logic [N_in-1:0]      bin_sr;
  logic [4*N_dig-1:0]   scratch;
  logic [4*N_dig-1:0]   corr;
  logic [CW-1:0]        cnt;

  // Per-digit add-3 so each digit stays in 0..9 after the next doubling.
  for (genvar g = 0; g < N_dig; g++) begin : g_dig
    assign corr[g*4 +: 4] = (scratch[g*4 +: 4] >= 4'd5) ? scratch[g*4 +: 4] + 4'd3
                                                        : scratch[g*4 +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            cnt     <= CW'(N_in);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {corr[4*N_dig-2:0], bin_sr[N_in-1]};
          bin_sr  <= {bin_sr[N_in-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= LOAD;
        end
        LOAD: begin
          bcd_out <= scratch;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
